mem_wb_stage_multi: RTL
=======================

Name: mem_wb_stage_multi

Overview:
Parametrised MEM/WB pipeline register for a multi-issue pipeline, the next generation of the single-channel MEM/WB latch. It carries NUM_CH write-back channels, each with a valid bit, and adds stall, flush and bubble handling. It provides combinational write-back bypass lookup ports for ID-stage register reads and counts retired register writes for the performance monitor. It sits between the MEM stage outputs and the register file write ports.

Parameters:
DATA_W, 32, width of the write-back data word
ADDR_W, 5, register address width
NUM_CH, 2, number of write-back channels (1..4); a higher index is a younger instruction
NUM_RD, 2, number of bypass lookup ports
CNT_W, 32, width of the retire counter

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous reset, active-high
stall_i  in  1  hold all stage contents
flush_i  in  1  invalidate all stage contents
mem_valid_i  in  NUM_CH  per-channel valid from MEM
mem_re_i  in  NUM_CH  per-channel read-enable tag
mem_we_i  in  NUM_CH  per-channel register write enable
mem_addr_i  in  NUM_CH*ADDR_W  per-channel destination address; channel k occupies bits [k*ADDR_W +: ADDR_W]
mem_data_i  in  NUM_CH*DATA_W  per-channel write-back data, packed the same way
wb_valid_o  out  NUM_CH  registered valid
wb_re_o  out  NUM_CH  registered read-enable tag
wb_we_o  out  NUM_CH  registered write enable, gated: it is 1 only when valid is 1
wb_addr_o  out  NUM_CH*ADDR_W  registered destination address
wb_data_o  out  NUM_CH*DATA_W  registered data
rd_addr_i  in  NUM_RD*ADDR_W  bypass lookup addresses
fwd_hit_o  out  NUM_RD  combinational: the lookup matches a pending write
fwd_data_o  out  NUM_RD*DATA_W  combinational forwarded data; 0 when there is no hit
retire_cnt_o  out  CNT_W  number of committed register writes

Behaviour:
- Control priority on each rising clk edge: rst > flush_i > stall_i > load.
- rst:
  - All wb_* outputs go to 0.
  - retire_cnt_o goes to 0.
  - Reset is honoured mid-stall and mid-flush; nothing is retained.
- flush_i:
  - wb_valid_o and wb_we_o go to 0 on all channels.
  - wb_re_o, wb_addr_o and wb_data_o go to 0 on all channels.
  - flush_i overrides a simultaneous stall_i.
- stall_i (no flush): every register holds its value. Outputs remain visible, so the register file re-writes the same value, which is harmless.
- Load (neither flush nor stall):
  - Channel k captures mem_*_i[k] with 1-cycle latency.
  - wb_we_o[k] takes mem_we_i[k] & mem_valid_i[k].
  - A channel with mem_valid_i[k]=0 loads as a bubble: valid=0, we=0, and re/addr/data are also zeroed.
- Writes to address 0 are legal to latch, but they are excluded from bypass. They still count as retired.
- Bypass lookup for port j, purely combinational from the current wb_* registers:
  - A candidate is any channel k with wb_we_o[k]=1, wb_addr_o[k]==rd_addr_i[j] and rd_addr_i[j]!=0.
  - fwd_hit_o[j]=1 if any candidate exists.
  - fwd_data_o[j] is the data of the highest-index candidate (the youngest instruction wins).
  - With no candidate: hit=0, data=0.
  - There is no path from mem_*_i to fwd_*; the lookup has no same-cycle input dependency.
- Retire counter:
  - On every edge that is not rst, flush or stall, retire_cnt_o increments by popcount(wb_we_o), evaluated before the update, i.e. the writes leaving the stage that cycle.
  - While stalled, the counter does not increment; the held writes are counted once, on the edge they leave.
  - A flush discards the contents without counting them.
  - Wrap-around is modulo 2^CNT_W with no saturation.
- Two channels may target the same address in the same cycle. The stage does not arbitrate; it passes both through. The register file is responsible for applying the highest-index channel last. The bypass mirrors this by picking the highest index.

Test Plan:
- Reset: drive rst=1 with all inputs at 1 -> after the edge, every wb_* output = 0 and retire_cnt_o = 0; hold rst and stall_i together for 3 cycles -> outputs stay 0.
- Load and latency: NUM_CH=2; ch0 valid, we=1, addr=5, data=0xDEADBEEF; ch1 valid=0, we=1 -> next cycle wb_we_o=2'b01, wb_addr_o[ch0]=5, ch1 all zero; the following edge -> retire_cnt_o=1.
- Bypass priority: both channels write addr 7, ch0 data=0x11, ch1 data=0x22; rd_addr_i[0]=7, rd_addr_i[1]=0 -> fwd_hit_o=2'b01, fwd_data_o[0]=0x22, fwd_data_o[1]=0; then ch1 we=0 -> fwd_data_o[0]=0x11.
- Stall: load addr 3 / data 0x55, then hold stall_i=1 for 4 cycles while the inputs change to addr 9 / data 0x66 -> outputs stay addr 3 / data 0x55; retire_cnt_o is unchanged until the first un-stalled edge, then it increases by exactly 1.
- Flush beats stall: with a valid write held, assert flush_i=1 and stall_i=1 together -> next cycle wb_valid_o=0, wb_we_o=0, fwd_hit_o=0; retire_cnt_o is not incremented.
- Counter wrap: CNT_W=4; preload 15 retirements, then retire 2 writes in one cycle -> retire_cnt_o=1.

Source files
------------

// File: rtl/mem_wb_stage_multi.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_multi
//
// MEM/WB pipeline register for a multi-issue pipeline. It holds NUM_CH
// write-back channels. A higher channel index is a younger instruction.
// The stage provides:
//   - stall / flush / bubble handling (priority: rst > flush > stall > load)
//   - combinational write-back bypass lookups for ID-stage register reads
//   - a retire counter of committed register writes
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stall_i           hold all stage contents
//   flush_i           invalidate all stage contents
//   mem_valid_i       per-channel valid from MEM                  [NUM_CH]
//   mem_re_i          per-channel read-enable tag                 [NUM_CH]
//   mem_we_i          per-channel register write enable           [NUM_CH]
//   mem_addr_i        per-channel dest address, ch k at [k*ADDR_W +: ADDR_W]
//   mem_data_i        per-channel data, ch k at [k*DATA_W +: DATA_W]
//   wb_valid_o        registered valid                            [NUM_CH]
//   wb_re_o           registered read-enable tag                  [NUM_CH]
//   wb_we_o           registered write enable (only 1 when valid) [NUM_CH]
//   wb_addr_o         registered destination addresses
//   wb_data_o         registered write-back data
//   rd_addr_i         bypass lookup addresses, port j at [j*ADDR_W +: ADDR_W]
//   fwd_hit_o         lookup j matches a pending write            [NUM_RD]
//   fwd_data_o        forwarded data; 0 when there is no hit
//   retire_cnt_o      committed register writes, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mem_wb_stage_multi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_CH = 2,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [NUM_CH-1:0]          mem_valid_i,
    input  logic [NUM_CH-1:0]          mem_re_i,
    input  logic [NUM_CH-1:0]          mem_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]   mem_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   mem_data_i,
    output logic [NUM_CH-1:0]          wb_valid_o,
    output logic [NUM_CH-1:0]          wb_re_o,
    output logic [NUM_CH-1:0]          wb_we_o,
    output logic [NUM_CH*ADDR_W-1:0]   wb_addr_o,
    output logic [NUM_CH*DATA_W-1:0]   wb_data_o,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD-1:0]          fwd_hit_o,
    output logic [NUM_RD*DATA_W-1:0]   fwd_data_o,
    output logic [CNT_W-1:0]           retire_cnt_o
);

    // Stage state
    logic [NUM_CH-1:0]        valid_q;
    logic [NUM_CH-1:0]        re_q;
    logic [NUM_CH-1:0]        we_q;
    logic [NUM_CH*ADDR_W-1:0] addr_q;
    logic [NUM_CH*DATA_W-1:0] data_q;
    logic [CNT_W-1:0]         cnt_q;

    // Load values: a channel without valid loads as an all-zero bubble, so
    // stale address/data never leaks into the write-back or bypass paths.
    logic [NUM_CH-1:0]        load_re;
    logic [NUM_CH-1:0]        load_we;
    logic [NUM_CH*ADDR_W-1:0] load_addr;
    logic [NUM_CH*DATA_W-1:0] load_data;

    // Number of writes leaving the stage on this edge.
    logic [CNT_W-1:0]         retire_inc;

    // NOTE: every signal written in an always_comb block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    always_comb begin
        load_re   = mem_re_i & mem_valid_i;
        load_we   = mem_we_i & mem_valid_i;
        load_addr = '0;
        load_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mem_valid_i[k]) begin
                load_addr[k*ADDR_W +: ADDR_W] = mem_addr_i[k*ADDR_W +: ADDR_W];
                load_data[k*DATA_W +: DATA_W] = mem_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        retire_inc = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            retire_inc = retire_inc + CNT_W'(we_q[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            re_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            // Flushed contents are discarded without being counted.
            valid_q <= '0;
            re_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (!stall_i) begin
            valid_q <= mem_valid_i;
            re_q    <= load_re;
            we_q    <= load_we;
            addr_q  <= load_addr;
            data_q  <= load_data;
            // Held writes are counted once, on the edge they leave the stage.
            cnt_q   <= cnt_q + retire_inc;
        end
    end

    assign wb_valid_o   = valid_q;
    assign wb_re_o      = re_q;
    assign wb_we_o      = we_q;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = data_q;
    assign retire_cnt_o = cnt_q;

    // Bypass lookup from the registered stage only; there is deliberately no
    // path from mem_*_i. Channels are scanned in ascending order so the
    // highest-index (youngest) match overwrites older ones, matching the
    // order in which the register file applies same-address writes.
    // Address 0 is never forwarded.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (we_q[k] &&
                    (rd_addr_i[j*ADDR_W +: ADDR_W] != '0) &&
                    (addr_q[k*ADDR_W +: ADDR_W] == rd_addr_i[j*ADDR_W +: ADDR_W])) begin
                    fwd_hit_o[j]                   = 1'b1;
                    fwd_data_o[j*DATA_W +: DATA_W] = data_q[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
